axi_stream_frame_receiver: RTL and testbench
============================================

Name: axi_stream_frame_receiver

Overview:
- Receiving end of the frequency-meter AXI-Stream link.
- Accepts fixed-length frames of FRAME_SIZE beats from an axi_if master and reassembles them into one result word.
- Presents the word to a downstream consumer (display or UART formatter) through a valid/ready handshake.
- Checks frame framing using tlast, applies backpressure while a result is unconsumed, and flags malformed frames.

Parameters:
- DATA_WIDTH, 8, tdata width per beat; must equal the axi_if data width.
- FRAME_SIZE, 4, beats per frame (minimum 2).
- VALUE_WIDTH, DATA_WIDTH*FRAME_SIZE, width of the reassembled result.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- axi  axi_if.slave  -  stream input; uses tvalid, tready, tdata[DATA_WIDTH-1:0], tlast.
- value  output  VALUE_WIDTH  last complete frame, first beat in the MSBs.
- value_valid  output  1  value holds an unconsumed result.
- value_ready  input  1  consumer accepts value when value_valid and value_ready are both high.
- frame_error  output  1  one-cycle pulse per malformed frame.
- frame_count  output  16  count of good frames delivered; wraps 0xFFFF->0.

Behaviour:
- Reset (async assert, sync release): state=COLLECT, beat_idx=0, shift register=0, value=0, value_valid=0, axi.tready=0, frame_error=0, frame_count=0.
- Beat transfer: a beat transfers when tvalid && tready on a rising clk edge. tready is registered; it never depends combinationally on tvalid.
- COLLECT state:
  - tready=1 on the cycle after reset release and whenever value_valid=0, or when value_valid=1 and value_ready=1 in the same cycle.
  - Each transfer shifts tdata into the LSBs of the shift register (so the first beat ends up in the MSBs) and increments beat_idx.
- Beat with beat_idx==FRAME_SIZE-1 and tlast=1 (good frame):
  - Next cycle: value=shift register, value_valid=1, frame_count+1, beat_idx=0.
  - Latency from the last beat's handshake edge to value_valid high is 1 cycle.
- Beat with beat_idx<FRAME_SIZE-1 and tlast=1 (short frame):
  - frame_error pulses 1 cycle; beat_idx=0; shift register discarded; value and value_valid unchanged; remain in COLLECT.
- Beat with beat_idx==FRAME_SIZE-1 and tlast=0 (long frame):
  - frame_error pulses 1 cycle; go to DISCARD.
- DISCARD state:
  - tready=1; beats are dropped until a beat with tlast=1 transfers; then COLLECT with beat_idx=0. No additional error pulse.
- Output hold and backpressure:
  - While value_valid=1 and value_ready=0, value is stable and tready=0 once the next frame's last beat would complete. Beats before the final beat of the next frame are still accepted, so a one-frame-deep overlap is allowed.
  - tready drops to 0 when beat_idx==FRAME_SIZE-1 and value_valid=1 and value_ready=0.
- Consumer handshake: value_valid clears on value_valid && value_ready, unless a new good frame completes in the same cycle. In that case value is loaded with the new frame and value_valid stays 1.
- Width rules:
  - beat_idx width is $clog2(FRAME_SIZE).
  - frame_count wraps without saturation.
  - VALUE_WIDTH is always derived, never overridden independently.
- Reset mid-frame: a partial frame is lost. After release the receiver is in COLLECT and treats the next beat as beat 0. Resync relies on the tlast checks above.
- tvalid low: no state change. Gaps between beats of arbitrary length are legal.

Decomposition:
- Shared package freq_meter_pkg holds:
  - typedef enum logic [0:0] {COLLECT, DISCARD} rx_state_t;
  - localparam defaults for DATA_WIDTH and FRAME_SIZE, shared with the transmitting master.
- One natural sub-module, frame_output_reg: holds value/value_valid with valid/ready handling, load-while-drain priority and the tready throttle term. The FSM and shift logic stay in the top module.

Test Plan:
- Good frame: beats 0x12,0x34,0x56,0x78, tlast on the 4th, value_ready=1 -> value=0x12345678, value_valid for 1 cycle, 1 cycle after the last beat; frame_count=1; frame_error stays 0.
- Short frame: 0xAA,0xBB with tlast on the 2nd, then good frame 0x01,0x02,0x03,0x04 -> 1 frame_error pulse; value=0x01020304; frame_count=1.
- Long frame: 6 beats 0x11..0x66, tlast on the 6th, then good frame 0xDE,0xAD,0xBE,0xEF -> 1 frame_error pulse at beat 4; beats 5-6 dropped; value=0xDEADBEEF.
- Backpressure: value_ready=0, send two good frames back to back -> first value held stable; tready=0 at the second frame's 4th beat until value_ready=1; then second value delivered; no beat lost; frame_count=2.
- Simultaneous drain/load: value_ready asserted on the same edge a new frame completes -> value switches to the new word; value_valid stays 1 with no gap.
- Async reset mid-frame: rst after 2 beats, then a full good frame 0xCAFEF00D -> all outputs 0 during reset; value=0xCAFEF00D afterwards; frame_count=1; no frame_error.

Source files
------------

// File: rtl/freq_meter_pkg.sv
// rtl/freq_meter_pkg.sv - shared types and defaults for the frequency-meter stream link
// Purpose: receiver state encoding and the beat/frame geometry shared by the
//          transmitting master and the receiving slave.
// Ports:   none (package).
package freq_meter_pkg;

    typedef enum logic [0:0] {
        COLLECT,
        DISCARD
    } rx_state_t;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_FRAME_SIZE = 4;

endpackage

// File: rtl/axi_if.sv
// rtl/axi_if.sv - stream link bundle between the frequency-meter master and receiver
// Purpose: carries one beat per tvalid && tready handshake, tlast marks frame end.
// Ports:   master drives tvalid/tdata/tlast and samples tready;
//          slave samples tvalid/tdata/tlast and drives tready.
interface axi_if #(
    parameter int DATA_WIDTH = freq_meter_pkg::DEFAULT_DATA_WIDTH
);
    logic                  tvalid;
    logic                  tready;
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tlast;

    modport master (output tvalid, output tdata, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/frame_output_reg.sv
// rtl/frame_output_reg.sv - result holding register with valid/ready drain
// Purpose: holds the last reassembled frame until the consumer takes it.
//          A load in the same cycle as a drain wins, so the output never gaps.
// Ports:   clk, rst          - clock, async active-high reset
//          load, load_value  - a good frame completes this cycle
//          at_last_beat      - receiver is waiting on a frame's final beat
//          value_ready       - consumer accepts value this cycle
//          value, value_valid- held result and its valid flag
//          throttle          - stall the stream: final beat would overwrite an unread result
module frame_output_reg #(
    parameter int VALUE_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic [VALUE_WIDTH-1:0] load_value,
    input  logic                   at_last_beat,
    input  logic                   value_ready,
    output logic [VALUE_WIDTH-1:0] value,
    output logic                   value_valid,
    output logic                   throttle
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value       <= '0;
            value_valid <= 1'b0;
        end else if (load) begin
            value       <= load_value;
            value_valid <= 1'b1;
        end else if (value_valid && value_ready) begin
            value_valid <= 1'b0;
        end
    end

    // Earlier beats of the next frame may overlap an unread result; only the
    // beat that would complete it must wait for the consumer.
    assign throttle = at_last_beat && value_valid && !value_ready;

endmodule

// File: rtl/axi_stream_frame_receiver.sv
// rtl/axi_stream_frame_receiver.sv - reassembles fixed-length stream frames into one word
// Purpose: collects FRAME_SIZE beats (first beat in the MSBs), checks framing
//          against tlast, drops over-long frames until the next tlast and
//          hands complete words to a valid/ready consumer.
// Ports:   clk, rst     - clock, async active-high reset
//          axi          - stream slave (tvalid, tready, tdata, tlast)
//          value        - last complete frame
//          value_valid  - value not yet consumed
//          value_ready  - consumer handshake
//          frame_error  - one-cycle pulse per malformed frame
//          frame_count  - good frames delivered, wrapping
module axi_stream_frame_receiver
    import freq_meter_pkg::*;
#(
    parameter  int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter  int FRAME_SIZE  = DEFAULT_FRAME_SIZE,
    localparam int VALUE_WIDTH = DATA_WIDTH * FRAME_SIZE
) (
    input  logic                   clk,
    input  logic                   rst,
    axi_if.slave                   axi,
    output logic [VALUE_WIDTH-1:0] value,
    output logic                   value_valid,
    input  logic                   value_ready,
    output logic                   frame_error,
    output logic [15:0]            frame_count
);

    localparam int                IDX_W    = $clog2(FRAME_SIZE);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(FRAME_SIZE - 1);

    rx_state_t              state;
    logic [IDX_W-1:0]       beat_idx;
    logic [VALUE_WIDTH-1:0] shift_reg;
    logic [VALUE_WIDTH-1:0] shift_next;
    logic                   ready_q;
    logic                   throttle;
    logic                   beat_fire;
    logic                   at_last_beat;
    logic                   good_frame;
    logic                   short_frame;
    logic                   long_frame;

    assign at_last_beat = (state == COLLECT) && (beat_idx == LAST_IDX);
    assign beat_fire    = axi.tvalid && axi.tready;
    assign good_frame   = beat_fire && at_last_beat && axi.tlast;
    assign long_frame   = beat_fire && at_last_beat && !axi.tlast;
    assign short_frame  = beat_fire && (state == COLLECT) && (beat_idx != LAST_IDX) && axi.tlast;
    assign shift_next   = {shift_reg[VALUE_WIDTH-DATA_WIDTH-1:0], axi.tdata};

    // ready_q is the registered enable (low in reset, high from the first
    // clock after release); the output stage only ever masks it.
    assign axi.tready = ready_q && !throttle;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= COLLECT;
            beat_idx    <= '0;
            shift_reg   <= '0;
            ready_q     <= 1'b0;
            frame_error <= 1'b0;
            frame_count <= '0;
        end else begin
            ready_q     <= 1'b1;
            frame_error <= short_frame || long_frame;
            if (good_frame) begin
                frame_count <= frame_count + 16'd1;
            end
            case (state)
                COLLECT: begin
                    if (beat_fire) begin
                        if (axi.tlast || at_last_beat) begin
                            beat_idx  <= '0;
                            shift_reg <= '0;
                            if (long_frame) begin
                                state <= DISCARD;
                            end
                        end else begin
                            beat_idx  <= beat_idx + IDX_W'(1);
                            shift_reg <= shift_next;
                        end
                    end
                end
                DISCARD: begin
                    if (beat_fire && axi.tlast) begin
                        state <= COLLECT;
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

    frame_output_reg #(
        .VALUE_WIDTH (VALUE_WIDTH)
    ) u_output (
        .clk          (clk),
        .rst          (rst),
        .load         (good_frame),
        .load_value   (shift_next),
        .at_last_beat (at_last_beat),
        .value_ready  (value_ready),
        .value        (value),
        .value_valid  (value_valid),
        .throttle     (throttle)
    );

endmodule

// File: tb/tb_axi_stream_frame_receiver.sv
// tb/tb_axi_stream_frame_receiver.sv - self-checking bench for axi_stream_frame_receiver
module tb_axi_stream_frame_receiver;

    localparam int DW = 8;
    localparam int FS = 4;
    localparam int VW = DW * FS;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          value_ready = 1'b0;
    logic [VW-1:0] value;
    logic          value_valid;
    logic          frame_error;
    logic [15:0]   frame_count;

    axi_if #(.DATA_WIDTH(DW)) axi();

    axi_stream_frame_receiver #(
        .DATA_WIDTH (DW),
        .FRAME_SIZE (FS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .axi         (axi),
        .value       (value),
        .value_valid (value_valid),
        .value_ready (value_ready),
        .frame_error (frame_error),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int err_seen = 0;
    bit done = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: beats of the current frame kept as a list; a frame
    // is judged only when tlast arrives or the list overflows.
    logic [7:0]  m_q[$];
    bit          m_discard = 0;
    logic [31:0] m_value = '0;
    bit          m_valid = 0;
    bit          m_err = 0;
    bit          m_ready_base = 0;
    logic [15:0] m_count = '0;
    bit          m_fire, m_drain, m_load;
    logic [31:0] m_word;

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_q.delete();
                m_discard = 0; m_value = '0; m_valid = 0; m_err = 0;
                m_ready_base = 0; m_count = '0;
            end else begin
                m_fire  = axi.tvalid && axi.tready;
                m_drain = m_valid && value_ready;
                m_load  = 0;
                m_err   = 0;
                m_word  = '0;
                if (m_fire) begin
                    if (m_discard) begin
                        if (axi.tlast) m_discard = 0;
                    end else begin
                        m_q.push_back(axi.tdata);
                        if (axi.tlast) begin
                            if (m_q.size() == FS) begin
                                foreach (m_q[i]) m_word = (m_word << 8) | 32'(m_q[i]);
                                m_load = 1;
                            end else begin
                                m_err = 1;
                            end
                            m_q.delete();
                        end else if (m_q.size() == FS) begin
                            m_err = 1;
                            m_discard = 1;
                            m_q.delete();
                        end
                    end
                end
                if (m_load) begin
                    m_value = m_word;
                    m_valid = 1;
                    m_count = m_count + 16'd1;
                end else if (m_drain) begin
                    m_valid = 0;
                end
                m_ready_base = 1;
            end
        end
    end

    bit exp_ready;
    initial begin
        forever begin
            @(negedge clk);
            if (!done) begin
                exp_ready = m_ready_base &&
                            !(!m_discard && m_q.size() == FS - 1 && m_valid && !value_ready);
                check("value", value, m_value);
                check("value_valid", 32'(value_valid), 32'(m_valid));
                check("frame_error", 32'(frame_error), 32'(m_err));
                check("frame_count", 32'(frame_count), 32'(m_count));
                check("tready", 32'(axi.tready), 32'(exp_ready));
                if (frame_error) err_seen++;
            end
        end
    end

    task automatic idle();
        axi.tvalid = 1'b0;
        axi.tlast  = 1'b0;
    endtask

    task automatic send_beat(input logic [7:0] d, input bit last);
        bit ok;
        axi.tvalid = 1'b1;
        axi.tdata  = d;
        axi.tlast  = last;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            ok = axi.tready;
            @(posedge clk);
            #2;
            if (ok) return;
        end
        n_cmp++;
        n_bad++;
        $display("FAIL beat_timeout: beat 0x%0h not accepted within 200 cycles", d);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < FS; i++) begin
            send_beat(w[31-8*i -: 8], i == FS - 1);
        end
        idle();
    endtask

    task automatic cycle();
        @(posedge clk);
        #2;
    endtask

    int e0;

    initial begin
        axi.tvalid = 1'b0;
        axi.tdata  = '0;
        axi.tlast  = 1'b0;
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_value", value, 32'h0);
        check("rst_tready", 32'(axi.tready), 32'h0);
        check("rst_count", 32'(frame_count), 32'h0);
        cycle();
        rst = 1'b0;

        // Good frame
        value_ready = 1'b1;
        send_word(32'h12345678);
        check("t1_value", value, 32'h12345678);
        check("t1_valid", 32'(value_valid), 32'h1);
        check("t1_count", 32'(frame_count), 32'd1);
        cycle();
        check("t1_valid_clear", 32'(value_valid), 32'h0);

        // Short frame then good frame
        e0 = err_seen;
        send_beat(8'hAA, 0);
        send_beat(8'hBB, 1);
        idle();
        send_word(32'h01020304);
        repeat (2) cycle();
        check("t2_errors", 32'(err_seen - e0), 32'd1);
        check("t2_value", value, 32'h01020304);
        check("t2_count", 32'(frame_count), 32'd2);

        // Long frame then good frame
        e0 = err_seen;
        for (int i = 1; i <= 6; i++) begin
            send_beat(8'(i * 17), i == 6);
            if (i == 4) check("t3_err_at_beat4", 32'(frame_error), 32'h1);
        end
        idle();
        send_word(32'hDEADBEEF);
        repeat (2) cycle();
        check("t3_errors", 32'(err_seen - e0), 32'd1);
        check("t3_value", value, 32'hDEADBEEF);
        check("t3_count", 32'(frame_count), 32'd3);

        // Backpressure: two frames back to back with consumer stalled
        value_ready = 1'b0;
        send_word(32'hA1A2A3A4);
        check("t4_first_valid", 32'(value_valid), 32'h1);
        send_beat(8'hB1, 0);
        send_beat(8'hB2, 0);
        send_beat(8'hB3, 0);
        axi.tvalid = 1'b1;
        axi.tdata  = 8'hB4;
        axi.tlast  = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("t4_tready_low", 32'(axi.tready), 32'h0);
            check("t4_hold", value, 32'hA1A2A3A4);
            cycle();
        end
        value_ready = 1'b1;
        @(negedge clk);
        check("t4_tready_release", 32'(axi.tready), 32'h1);
        cycle();
        idle();
        value_ready = 1'b0;
        check("t4_value", value, 32'hB1B2B3B4);
        check("t4_valid", 32'(value_valid), 32'h1);
        check("t4_count", 32'(frame_count), 32'd5);

        // Drain and load on the same edge
        send_beat(8'hC1, 0);
        send_beat(8'hC2, 0);
        send_beat(8'hC3, 0);
        value_ready = 1'b1;
        send_beat(8'hC4, 1);
        idle();
        value_ready = 1'b0;
        check("t5_value", value, 32'hC1C2C3C4);
        check("t5_valid", 32'(value_valid), 32'h1);
        check("t5_count", 32'(frame_count), 32'd6);
        value_ready = 1'b1;
        cycle();
        check("t5_drained", 32'(value_valid), 32'h0);

        // Reset in the middle of a frame
        send_beat(8'h55, 0);
        send_beat(8'h66, 0);
        idle();
        #1 rst = 1'b1;
        @(negedge clk);
        check("t6_rst_value", value, 32'h0);
        check("t6_rst_valid", 32'(value_valid), 32'h0);
        check("t6_rst_count", 32'(frame_count), 32'h0);
        check("t6_rst_tready", 32'(axi.tready), 32'h0);
        cycle();
        rst = 1'b0;
        e0 = err_seen;
        send_word(32'hCAFEF00D);
        repeat (2) cycle();
        check("t6_value", value, 32'hCAFEF00D);
        check("t6_count", 32'(frame_count), 32'd1);
        check("t6_errors", 32'(err_seen - e0), 32'd0);

        done = 1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
